// File: rtl/pll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pll_reconfig_pkg
//  Purpose : Shared definitions for the PLL reconfiguration sequencer:
//            reconfig register addresses, sequencer state encoding, the
//            preset record type, the constant preset table and helpers
//            that map (preset, step) to the register address and write data.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pll_reconfig_pkg;

   // Reconfig register addresses
   localparam logic [5:0] PLL_A_MODE  = 6'd0;
   localparam logic [5:0] PLL_A_START = 6'd2;
   localparam logic [5:0] PLL_A_N     = 6'd3;
   localparam logic [5:0] PLL_A_M     = 6'd4;
   localparam logic [5:0] PLL_A_C     = 6'd5;
   localparam logic [5:0] PLL_A_K     = 6'd7;

   // Index of the final write of every script
   localparam logic [2:0] PLL_LAST_STEP = 3'd5;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_PRE   = 3'd2,
      ST_RAISE = 3'd3,
      ST_LOWER = 3'd4,
      ST_NEXT  = 3'd5,
      ST_FIN   = 3'd6,
      ST_FAIL  = 3'd7
   } pll_state_t;

   // One clock preset: counter words written during steps 1..4
   typedef struct packed {
      logic [31:0] m;
      logic [31:0] n;
      logic [31:0] c;   // C0 word, counter select lives in the upper bits
      logic [31:0] k;
   } pll_preset_t;

   localparam int PLL_TABLE_DEPTH = 4;

   localparam pll_preset_t PLL_PRESETS [PLL_TABLE_DEPTH] = '{
      '{m: 32'h0000_0C0C, n: 32'h0001_0000, c: 32'h0000_0303, k: 32'h0000_0000},
      '{m: 32'h0000_1010, n: 32'h0000_0202, c: 32'h0004_0505, k: 32'h8000_0000},
      '{m: 32'h0000_0F0F, n: 32'h0000_0101, c: 32'h0008_0606, k: 32'h4000_0000},
      '{m: 32'h0000_1414, n: 32'h0000_0505, c: 32'h000C_0202, k: 32'h0000_0000}
   };

   // Out-of-table indices return an all-zero record; legality is decided
   // separately by the sequencer against its NUM_PRESETS parameter.
   function automatic pll_preset_t pll_preset_lookup(input logic [2:0] idx);
      pll_preset_t p;
      p = '0;
      if (idx < 3'(PLL_TABLE_DEPTH)) begin
         p = PLL_PRESETS[idx[1:0]];
      end
      return p;
   endfunction

   function automatic logic [5:0] pll_step_addr(input logic [2:0] step);
      logic [5:0] a;
      case (step)
         3'd0:    a = PLL_A_MODE;
         3'd1:    a = PLL_A_M;
         3'd2:    a = PLL_A_N;
         3'd3:    a = PLL_A_C;
         3'd4:    a = PLL_A_K;
         default: a = PLL_A_START;
      endcase
      return a;
   endfunction

   // Step 0 writes 0 to the mode register (waitrequest mode); step 5 writes
   // 0 to the start register.
   function automatic logic [31:0] pll_step_value(input pll_preset_t p,
                                                  input logic [2:0] step);
      logic [31:0] v;
      case (step)
         3'd1:    v = p.m;
         3'd2:    v = p.n;
         3'd3:    v = p.c;
         3'd4:    v = p.k;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_seq_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module  : sync_bit
//  Purpose : Single-bit multi-flop synchronizer with a selectable reset value.
//  Ports   : clk    - destination clock
//            reset  - synchronous active-high reset (loads RESET_VAL)
//            i_d    - asynchronous input bit
//            o_q    - synchronized output, DEPTH cycles behind i_d
//  Rev     : 1.0  initial release
// ============================================================================
module sync_bit #(
   parameter int   DEPTH     = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [DEPTH-1:0] r_sync;

   // Shift form keeps DEPTH=1 legal without a special case.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {DEPTH{RESET_VAL}};
      end else begin
         r_sync <= (r_sync << 1) | DEPTH'(i_d);
      end
   end

   assign o_q = r_sync[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
//  Module  : pll_reconfig_seq
//  Purpose : Requester-side PLL reconfiguration sequencer. On a request it
//            plays back a fixed six-write script for the selected preset
//            using a level handshake (pll_write / pll_busy) toward the
//            CLK_50M domain, then pulses done, or err on timeout / bad preset.
//  Ports   : clk        - system clock
//            reset      - synchronous active-high reset
//            req        - start pulse, honoured only while ready
//            req_preset - preset index, latched with req
//            ready      - idle, able to accept req
//            done       - one-cycle pulse on successful completion
//            err        - one-cycle pulse on timeout or illegal preset
//            pll_addr   - reconfig register address
//            pll_value  - reconfig write data
//            pll_write  - write request level (registered, crosses domains)
//            pll_busy   - busy level from the CLK_50M domain (asynchronous)
//  Rev     : 1.0  initial release
// ============================================================================
module pll_reconfig_seq
   import pll_reconfig_pkg::*;
#(
   parameter int NUM_PRESETS    = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [2:0]  req_preset,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [5:0]  pll_addr,
   output logic [31:0] pll_value,
   output logic        pll_write,
   input  logic        pll_busy
);

   localparam logic [15:0] C_TIMEOUT     = 16'(TIMEOUT_CYCLES);
   localparam logic [3:0]  C_NUM_PRESETS = 4'(NUM_PRESETS);

   pll_state_t  r_state;
   pll_state_t  w_state_nxt;
   logic [2:0]  r_step;
   logic [2:0]  w_step_nxt;
   logic [2:0]  r_preset;
   logic [15:0] r_phase_cnt;
   logic [5:0]  r_pll_addr;
   logic [31:0] r_pll_value;
   logic        r_pll_write;

   logic        w_busy_s;
   logic        w_tmo;
   logic        w_preset_bad;
   logic        w_ready;
   logic        w_done;
   logic        w_err;
   pll_preset_t w_preset_rec;

   // Busy is presumed asserted until the synchronizer has seen it low, so
   // nothing is written while the far side may still be starting up.
   sync_bit #(
      .DEPTH     (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_busy_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (pll_busy),
      .o_q   (w_busy_s)
   );

   assign w_tmo        = (r_phase_cnt == C_TIMEOUT);
   assign w_preset_bad = ({1'b0, r_preset} >= C_NUM_PRESETS);
   assign w_preset_rec = pll_preset_lookup(r_preset);

   // ------------------------------------------------------------------------
   // Next state, step index and status outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_ready     = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (req) begin
               w_state_nxt = ST_CHECK;
               w_step_nxt  = 3'd0;
            end
         end
         ST_CHECK: begin
            w_state_nxt = w_preset_bad ? ST_FAIL : ST_PRE;
         end
         ST_PRE: begin
            if (!w_busy_s) begin
               w_state_nxt = ST_RAISE;
            end else if (w_tmo) begin
               w_state_nxt = ST_FAIL;
            end
         end
         ST_RAISE: begin
            // Write stays high until busy is seen, so the far-side edge
            // detector catches it whatever the clock ratio.
            if (w_busy_s) begin
               w_state_nxt = ST_LOWER;
            end else if (w_tmo) begin
               w_state_nxt = ST_FAIL;
            end
         end
         ST_LOWER: begin
            if (!w_busy_s) begin
               w_state_nxt = ST_NEXT;
            end else if (w_tmo) begin
               w_state_nxt = ST_FAIL;
            end
         end
         ST_NEXT: begin
            if (r_step == PLL_LAST_STEP) begin
               w_state_nxt = ST_FIN;
            end else begin
               w_step_nxt  = r_step + 3'd1;
               w_state_nxt = ST_PRE;
            end
         end
         ST_FIN: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         ST_FAIL: begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_step      <= 3'd0;
         r_preset    <= 3'd0;
         r_phase_cnt <= 16'd0;
         r_pll_addr  <= 6'd0;
         r_pll_value <= 32'd0;
         r_pll_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;

         if (r_state == ST_IDLE && req) begin
            r_preset <= req_preset;
         end

         // Phase timer restarts on every transition and saturates so it
         // cannot wrap back below the timeout threshold.
         if (w_state_nxt != r_state) begin
            r_phase_cnt <= 16'd0;
         end else if (r_phase_cnt != 16'hFFFF) begin
            r_phase_cnt <= r_phase_cnt + 16'd1;
         end

         // Address/data are loaded while heading into or sitting in PRE, so
         // they are already valid in PRE and frozen through RAISE/LOWER.
         if (w_state_nxt == ST_PRE) begin
            r_pll_addr  <= pll_step_addr(w_step_nxt);
            r_pll_value <= pll_step_value(w_preset_rec, w_step_nxt);
         end

         // Registered from the next state so the level leaving this domain
         // is glitch-free yet tracks RAISE cycle for cycle.
         r_pll_write <= (w_state_nxt == ST_RAISE);
      end
   end

   assign ready     = w_ready;
   assign done      = w_done;
   assign err       = w_err;
   assign pll_addr  = r_pll_addr;
   assign pll_value = r_pll_value;
   assign pll_write = r_pll_write;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pll_reconfig_seq
//  Purpose : Directed self-checking bench for pll_reconfig_seq with a simple
//            CLK_50M-side busy responder model and a write monitor.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pll_reconfig_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [2:0]  req_preset;
   logic        ready;
   logic        done;
   logic        err;
   logic [5:0]  pll_addr;
   logic [31:0] pll_value;
   logic        pll_write;
   logic        pll_busy = 1'b0;

   always #5 clk = ~clk;

   pll_reconfig_seq dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_preset (req_preset),
      .ready      (ready),
      .done       (done),
      .err        (err),
      .pll_addr   (pll_addr),
      .pll_value  (pll_value),
      .pll_write  (pll_write),
      .pll_busy   (pll_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Expected script for preset 1, typed in by hand
   logic [5:0]  exp_addr [6] = '{6'd0, 6'd4, 6'd3, 6'd5, 6'd7, 6'd2};
   logic [31:0] exp_p1   [6] = '{32'h0, 32'h0000_1010, 32'h0000_0202,
                                 32'h0004_0505, 32'h8000_0000, 32'h0};

   // Responder: 0 = normal (busy 5 cycles after write, low 20 later),
   // 1 = busy forced high, 2 = never responds
   int m_mode   = 0;
   int m_cnt    = 0;
   bit m_active = 1'b0;

   always @(negedge clk) begin
      case (m_mode)
         1: begin pll_busy = 1'b1; m_active = 1'b0; end
         2: begin pll_busy = 1'b0; m_active = 1'b0; end
         default: begin
            if (!m_active) begin
               pll_busy = 1'b0;
               if (pll_write) begin
                  m_active = 1'b1;
                  m_cnt    = 0;
               end
            end else begin
               m_cnt++;
               if (m_cnt == 5) pll_busy = 1'b1;
               else if (m_cnt == 25) begin
                  pll_busy = 1'b0;
                  m_active = 1'b0;
               end
            end
         end
      endcase
   end

   // Monitor
   int          n_wr = 0, n_done = 0, n_err = 0, n_unstable = 0;
   logic [5:0]  q_addr [$];
   logic [31:0] q_val  [$];
   logic        mon_wr = 1'b0;
   logic [5:0]  mon_addr = '0;
   logic [31:0] mon_val = '0;

   always @(negedge clk) begin
      if (pll_write === 1'b1 && mon_wr !== 1'b1) begin
         n_wr++;
         q_addr.push_back(pll_addr);
         q_val.push_back(pll_value);
      end
      if (pll_write === 1'b1 && mon_wr === 1'b1 &&
          (pll_addr !== mon_addr || pll_value !== mon_val)) n_unstable++;
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      mon_wr   = pll_write;
      mon_addr = pll_addr;
      mon_val  = pll_value;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_req(input logic [2:0] p);
      req_preset = p;
      req        = 1'b1;
      tick();
      req        = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   initial begin
      bit ok;
      int wr0, dn0, er0, cyc;

      reset = 1'b1; req = 1'b0; req_preset = 3'd0;
      repeat (3) tick();

      // Reset state
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_write", pll_write, 0);
      check("rst_addr", pll_addr, 0);
      check("rst_value", pll_value, 0);
      reset = 1'b0;
      repeat (5) tick();

      // Nominal run, preset 1, with first-write latency
      q_addr.delete(); q_val.delete();
      wr0 = n_wr; dn0 = n_done; er0 = n_err;
      pulse_req(3'd1);
      check("lat_check", pll_write, 0);
      check("lat_ready_low", ready, 0);
      tick();
      check("lat_pre", pll_write, 0);
      tick();
      check("lat_raise", pll_write, 1);
      wait_done(2000, ok);
      check("nom_done_seen", ok, 1);
      check("nom_ready_in_done", ready, 0);
      tick();
      check("nom_ready_after", ready, 1);
      check("nom_done_1cyc", done, 0);
      check("nom_wr_count", n_wr - wr0, 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("nom_addr%0d", i), q_addr[i], exp_addr[i]);
         check($sformatf("nom_val%0d", i), q_val[i], exp_p1[i]);
      end
      check("nom_done_count", n_done - dn0, 1);
      check("nom_err_count", n_err - er0, 0);
      check("nom_stable", n_unstable, 0);

      // Illegal preset
      repeat (5) tick();
      wr0 = n_wr;
      pulse_req(3'd5);
      check("ill_err_early", err, 0);
      tick();
      check("ill_err", err, 1);
      check("ill_write", pll_write, 0);
      tick();
      check("ill_err_1cyc", err, 0);
      check("ill_ready", ready, 1);
      repeat (10) tick();
      check("ill_no_write", n_wr - wr0, 0);

      // Startup busy held high for 200 cycles
      m_mode = 1;
      repeat (10) tick();
      wr0 = n_wr; dn0 = n_done;
      q_addr.delete(); q_val.delete();
      pulse_req(3'd1);
      repeat (189) tick();
      check("sb_no_write", n_wr - wr0, 0);
      check("sb_write_low", pll_write, 0);
      check("sb_not_ready", ready, 0);
      m_mode = 0;
      wait_done(2000, ok);
      check("sb_done_seen", ok, 1);
      tick();
      check("sb_wr_count", n_wr - wr0, 6);
      check("sb_done_count", n_done - dn0, 1);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("sb_addr%0d", i), q_addr[i], exp_addr[i]);
      end

      // Request during step 2 is ignored
      repeat (5) tick();
      wr0 = n_wr; dn0 = n_done;
      q_addr.delete(); q_val.delete();
      pulse_req(3'd1);
      for (int i = 0; i < 500 && (n_wr - wr0) < 3; i++) tick();
      check("ign_reached_step2", n_wr - wr0, 3);
      pulse_req(3'd0);
      wait_done(2000, ok);
      check("ign_done_seen", ok, 1);
      repeat (60) tick();
      check("ign_wr_count", n_wr - wr0, 6);
      check("ign_done_count", n_done - dn0, 1);
      check("ign_ready", ready, 1);
      check("ign_val3", q_val[3], exp_p1[3]);
      check("ign_val4", q_val[4], exp_p1[4]);

      // Reset during step 3 RAISE
      repeat (5) tick();
      wr0 = n_wr;
      pulse_req(3'd2);
      for (int i = 0; i < 500 && (n_wr - wr0) < 4; i++) tick();
      check("rm_reached_step3", n_wr - wr0, 4);
      tick();
      check("rm_in_raise", pll_write, 1);
      reset = 1'b1;
      tick();
      check("rm_write_low", pll_write, 0);
      check("rm_ready", ready, 1);
      check("rm_addr", pll_addr, 0);
      reset = 1'b0;
      repeat (40) tick();
      wr0 = n_wr; dn0 = n_done;
      q_addr.delete(); q_val.delete();
      pulse_req(3'd0);
      wait_done(2000, ok);
      check("rm_done_seen", ok, 1);
      tick();
      check("rm_wr_count", n_wr - wr0, 6);
      check("rm_first_addr", q_addr[0], 0);
      check("rm_last_addr", q_addr[5], 2);
      check("rm_done_count", n_done - dn0, 1);

      // Timeout: responder never raises busy
      repeat (5) tick();
      m_mode = 2;
      er0 = n_err;
      pulse_req(3'd0);
      cyc = 0; ok = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         if (err === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (pll_write === 1'b1) cyc++;
         tick();
      end
      check("tmo_err_seen", ok, 1);
      check("tmo_write_low", pll_write, 0);
      check("tmo_len", (cyc >= 65535 && cyc <= 65536), 1);
      tick();
      check("tmo_ready", ready, 1);
      check("tmo_err_1cyc", err, 0);
      check("tmo_err_count", n_err - er0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Requester-side sequencer for the PLL reconfiguration handshake. It sits inside `system` in the `clk` (clk_sys) domain and drives `pll_addr`/`pll_value`/`pll_write`. The top level edge-detects `pll_write` in the CLK_50M domain, forwards one `mgmt_write` to `pll_cfg`, and returns `pll_busy` (asserted while `pll_write` is high or `mgmt_waitrequest` is high). On request, the block plays back a fixed six-write register sequence for the selected clock preset, then reports done or error.

## Interface
Parameters:
- `NUM_PRESETS`, 4: number of preset entries in the package table; `req_preset` values at or above this are illegal.
- `TIMEOUT_CYCLES`, 65535: maximum `clk` cycles allowed per handshake phase.
- `SYNC_STAGES`, 2: flip-flop stages in the `pll_busy` synchronizer.

Ports:
- `clk`, in, 1: clk_sys. The only clock.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 1: single-cycle start pulse. Sampled only when `ready`=1.
- `req_preset`, in, 3: preset index, latched with `req`.
- `ready`, out, 1: idle and able to accept `req`.
- `done`, out, 1: one-cycle pulse when the sequence completes.
- `err`, out, 1: one-cycle pulse on timeout or an illegal preset.
- `pll_addr`, out, 6: reconfig register address.
- `pll_value`, out, 32: reconfig write data.
- `pll_write`, out, 1: write request level toward the 50M domain.
- `pll_busy`, in, 1: asynchronous (CLK_50M domain). Synchronized internally.

## Operation
- Each preset is a 6-step script, played in this order:
  - step 0: addr 0 (mode), value 0 (waitrequest mode)
  - step 1: addr 4 (M)
  - step 2: addr 3 (N)
  - step 3: addr 5 (C0, value includes counter select)
  - step 4: addr 7 (M fractional K)
  - step 5: addr 2 (start), value 0
- FSM states: IDLE, CHECK, PRE, RAISE, LOWER, NEXT, FIN, FAIL.
- IDLE: `ready`=1. On `req`, latch the preset, set step=0, go to CHECK.
- CHECK: if the preset ≥ `NUM_PRESETS`, go to FAIL; otherwise go to PRE.
- PRE: drive `pll_addr`/`pll_value` from the table. Wait until `busy_s`=0, then go to RAISE.
- RAISE: `pll_write`=1. Wait for `busy_s`=1, then go to LOWER.
- LOWER: `pll_write`=0. Wait for `busy_s`=0, then go to NEXT.
- NEXT: if step=5, go to FIN; otherwise increment step and go to PRE.
- FIN: `done`=1 for one cycle, then go to IDLE.
- FAIL: `err`=1 for one cycle, `pll_write`=0, then go to IDLE.
- Timeout: a 16-bit phase counter clears on every state change. If it reaches `TIMEOUT_CYCLES` in PRE, RAISE or LOWER, go to FAIL.
- `pll_addr`/`pll_value` stay stable from PRE through LOWER. They change only in PRE.
- `pll_write` is held high until busy is observed. This guarantees the 50M-side edge detector sees it regardless of the clock ratio.
- A `req` outside IDLE is ignored. It is not queued.
- Reset mid-sequence: on the next edge `pll_write`=0 and the FSM is in IDLE. Any half-written PLL state is left to the requester, which re-requests.

## Timing
- Reset values:
  - `ready`=1
  - `done`=0, `err`=0
  - `pll_write`=0
  - `pll_addr`=0, `pll_value`=0
  - step=0
  - synchronizer flops=1 (busy is presumed until observed low)
- `busy_s` lags `pll_busy` by `SYNC_STAGES` cycles.
- `req` → first `pll_write` rise: a minimum of 3 cycles (CHECK, PRE, RAISE), given `busy_s`=0.
- Each write takes at least 4 `clk` cycles plus two synchronizer round trips plus the 50M-side latency.
- `done` rises the cycle after the NEXT that follows step 5. `ready` rises on the cycle after `done`.
- Simultaneous `req` and `reset`: reset wins.

## Structure
- Package `pll_reconfig_pkg` holds:
  - the address constants (`PLL_A_MODE`=0, `PLL_A_START`=2, `PLL_A_N`=3, `PLL_A_M`=4, `PLL_A_C`=5, `PLL_A_K`=7);
  - the state enum type;
  - the typedef `pll_preset_t` with fields m, n, c, k, each 32-bit;
  - the constant preset array.
- Sub-module `sync_bit` (parameterized depth, reset value) provides the `pll_busy` synchronizer.
- Everything else lives in this module.

## Test plan
- Nominal run: bench model raises busy 5 cycles after `pll_write` and drops it 20 cycles later. `req`, preset 1 → writes seen in the order addr 0,4,3,5,7,2 with the preset-1 values; `done` pulses once; `err` stays 0.
- Startup busy: `pll_busy` held 1 for 200 cycles, `req` at cycle 10 → no `pll_write` before busy falls, then a normal run.
- Timeout: the model never asserts busy in response to `pll_write` → `err` pulse after 65535 cycles in RAISE, `pll_write` returns to 0, `ready`=1.
- Illegal preset: `req_preset`=5 with `NUM_PRESETS`=4 → `err` 2 cycles after `req`; no `pll_write` at all.
- Reset mid-sequence: reset asserted during step 3 RAISE → `pll_write`=0 and `ready`=1 next cycle. A new `req` then restarts at addr 0.
- Ignored request: `req` pulsed during step 2 → exactly 6 writes and one `done`.
